// File: rtl/sync_fifo_pkg.sv
// Shared types and elaboration helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

  // Accepted-operation class for one edge, encoded as {write_accept, read_accept}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit params_legal(input int width, input int depth,
                                      input int af_thresh, input int ae_thresh);
    return (width >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh >= 0) && (ae_thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write port, registered read port cleared by rst.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic                        we,
  input  logic [ptr_width(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        re,
  input  logic [ptr_width(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]            rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // A same-address write in this cycle is not visible here, so a read while full returns the oldest word.
  always_ff @(posedge clock) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count and threshold flags.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          wr,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          rd,
  output logic [WIDTH-1:0]              data_out,
  output logic                          rd_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [count_width(DEPTH)-1:0] count
`ifdef SYNC_FIFO_ERR_EN
  ,
  input  logic                          err_clr,
  output logic                          overflow,
  output logic                          underflow
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);

  if (!params_legal(WIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("sync_fifo_param: illegal WIDTH/DEPTH/threshold parameters");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          rd_acc;
  logic          wr_acc;
  fifo_op_e      op;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  // A write at full is accepted only when a read frees a slot on the same edge.
  always_comb begin
    rd_acc = rd && !empty;
    wr_acc = wr && (!full || rd);
    op     = fifo_op_e'({wr_acc, rd_acc});
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      case (op)
        OP_WRITE: count <= count + CW'(1);
        OP_READ:  count <= count - CW'(1);
        default:  count <= count;
      endcase
    end
  end

  sync_fifo_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clock(clock),
    .rst  (rst),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .wdata(data_in),
    .re   (rd_acc),
    .raddr(rd_ptr),
    .rdata(data_out)
  );

`ifdef SYNC_FIFO_ERR_EN
  // A new error on the clearing edge wins over err_clr.
  always_ff @(posedge clock) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full && !rd) overflow <= 1'b1;
      else if (err_clr)      overflow <= 1'b0;
      if (rd && empty)       underflow <= 1'b1;
      else if (err_clr)      underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: queue-based reference model plus directed literal checks.
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic             clock = 1'b0;
  logic             rst   = 1'b1;
  logic             wr    = 1'b0;
  logic             rd    = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid, full, empty, almost_full, almost_empty;
  logic [5:0]       count;
`ifdef SYNC_FIFO_ERR_EN
  logic             err_clr = 1'b0;
  logic             overflow, underflow;
`endif

  int errors = 0;
  int checks = 0;

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clock(clock), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd),
    .data_out(data_out), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count)
`ifdef SYNC_FIFO_ERR_EN
    , .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, registered outputs as plain variables.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_dout = '0;
  logic             m_rv   = 1'b0;
  logic             m_ovf  = 1'b0;
  logic             m_udf  = 1'b0;

  // At each falling edge: compare DUT to model, then advance the model by the inputs
  // that the next rising edge will sample (inputs change only just after rising edges).
  initial begin
    forever begin
      int  sz;
      bit  r_ok, w_ok;
      @(negedge clock);
      sz = mq.size();
      chk("m_count",    32'(count),        32'(sz));
      chk("m_empty",    32'(empty),        32'(sz == 0));
      chk("m_full",     32'(full),         32'(sz == DEPTH));
      chk("m_afull",    32'(almost_full),  32'(sz >= AF));
      chk("m_aempty",   32'(almost_empty), 32'(sz <= AE));
      chk("m_rd_valid", 32'(rd_valid),     32'(m_rv));
      chk("m_data_out", 32'(data_out),     32'(m_dout));
`ifdef SYNC_FIFO_ERR_EN
      chk("m_overflow",  32'(overflow),  32'(m_ovf));
      chk("m_underflow", 32'(underflow), 32'(m_udf));
`endif
      if (rst) begin
        mq.delete();
        m_dout = '0;
        m_rv   = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
      end else begin
        r_ok = rd && (sz > 0);
        w_ok = wr && ((sz < DEPTH) || rd);
        m_rv = r_ok;
        if (r_ok) m_dout = mq.pop_front();
        if (w_ok) mq.push_back(data_in);
`ifdef SYNC_FIFO_ERR_EN
        if (wr && (sz == DEPTH) && !rd) m_ovf = 1'b1;
        else if (err_clr)               m_ovf = 1'b0;
        if (rd && (sz == 0))            m_udf = 1'b1;
        else if (err_clr)               m_udf = 1'b0;
`endif
      end
    end
  end

  // One cycle of stimulus; returns just after the rising edge that sampled it.
  task automatic cyc(input logic w, input logic r, input logic [WIDTH-1:0] d,
                     input logic rs = 1'b0, input logic ec = 1'b0);
    wr      = w;
    rd      = r;
    data_in = d;
    rst     = rs;
`ifdef SYNC_FIFO_ERR_EN
    err_clr = ec;
`else
    if (ec) ;
`endif
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset then idle
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00);
    chk("rst_empty",    32'(empty),        32'd1);
    chk("rst_aempty",   32'(almost_empty), 32'd1);
    chk("rst_full",     32'(full),         32'd0);
    chk("rst_afull",    32'(almost_full),  32'd0);
    chk("rst_count",    32'(count),        32'd0);
    chk("rst_data_out", 32'(data_out),     32'd0);
    chk("rst_rd_valid", 32'(rd_valid),     32'd0);

    // Fill 0x00..0x1F
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      if (i == 1)  chk("fill_aempty_at2",  32'(almost_empty), 32'd1);
      if (i == 2)  chk("fill_aempty_at3",  32'(almost_empty), 32'd0);
      if (i == 28) chk("fill_afull_at29",  32'(almost_full),  32'd0);
      if (i == 29) chk("fill_afull_at30",  32'(almost_full),  32'd1);
      if (i == 30) chk("fill_full_at31",   32'(full),         32'd0);
    end
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_count", 32'(count), 32'd32);

    // Full with write+read: oldest word out, count unchanged
    cyc(1'b1, 1'b1, 8'hAA);
    chk("fullrw_data",  32'(data_out), 32'h00);
    chk("fullrw_valid", 32'(rd_valid), 32'd1);
    chk("fullrw_count", 32'(count),    32'd32);

    // Write alone at full is dropped
    cyc(1'b1, 1'b0, 8'hBB);
    chk("ovf_count", 32'(count), 32'd32);
`ifdef SYNC_FIFO_ERR_EN
    chk("ovf_flag", 32'(overflow), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);
`endif

    // Drain: 0x01..0x1F then 0xAA
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk("drain_data",  32'(data_out), (i < DEPTH - 1) ? 32'(i + 1) : 32'hAA);
      chk("drain_valid", 32'(rd_valid), 32'd1);
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Empty with write+read: no read-through
    cyc(1'b1, 1'b1, 8'h55);
    chk("emptyrw_valid", 32'(rd_valid), 32'd0);
    chk("emptyrw_count", 32'(count),    32'd1);
    chk("emptyrw_hold",  32'(data_out), 32'hAA);
    cyc(1'b0, 1'b1, 8'h00);
    chk("emptyrw_read", 32'(data_out), 32'h55);

    // Read at empty is dropped
    cyc(1'b0, 1'b1, 8'h00);
    chk("udf_valid", 32'(rd_valid), 32'd0);
    chk("udf_hold",  32'(data_out), 32'h55);
`ifdef SYNC_FIFO_ERR_EN
    chk("udf_flag", 32'(underflow), 32'd1);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    chk("udf_clr_vs_new", 32'(underflow), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("udf_clr", 32'(underflow), 32'd0);
`endif

    // Wrap-around at count 5
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 8'(k));
    for (int j = 0; j < 100; j++) begin
      cyc(1'b1, 1'b1, 8'(j + 5));
      chk("wrap_data",  32'(data_out), 32'(8'(j)));
      chk("wrap_count", 32'(count),    32'd5);
    end
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 8'h00);
    chk("wrap_last", 32'(data_out), 32'd104);
    chk("wrap_empty", 32'(empty), 32'd1);

    // Reset mid-operation at count 17
    for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i));
    chk("pre_rst_count", 32'(count), 32'd17);
    cyc(1'b1, 1'b1, 8'hEE, 1'b1);
    chk("midrst_count", 32'(count),    32'd0);
    chk("midrst_empty", 32'(empty),    32'd1);
    chk("midrst_data",  32'(data_out), 32'd0);
    chk("midrst_valid", 32'(rd_valid), 32'd0);
    cyc(1'b1, 1'b0, 8'h3C);
    cyc(1'b0, 1'b1, 8'h00);
    chk("post_rst_data", 32'(data_out), 32'h3C);
    cyc(1'b0, 1'b1, 8'h00);
    chk("post_rst_empty", 32'(rd_valid), 32'd0);
    chk("post_rst_hold",  32'(data_out), 32'h3C);

    cyc(1'b0, 1'b0, 8'h00);
    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous single-clock FIFO, the next generation of the team's 8x32 byte FIFO. It is generalised in data width and depth and uses all DEPTH entries (full at DEPTH, not DEPTH-1). It adds occupancy count, programmable almost-full/almost-empty flags, a read-valid strobe, defined simultaneous read/write behaviour at both boundaries, and optional sticky overflow/underflow error flags. It sits between producer and consumer logic in the same clock domain.

## Interface
Parameters:
- WIDTH, 8: data word width in bits, ≥1.
- DEPTH, 32: number of entries; power of two, ≥4.
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH; range 1..DEPTH.
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH; range 0..DEPTH-1.

Ports:
- clock  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr  in  1  write request.
- data_in  in  WIDTH  write data.
- rd  in  1  read request.
- data_out  out  WIDTH  registered read data.
- rd_valid  out  1  data_out updated by a read accepted at the previous edge.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- err_clr  in  1  clears sticky error flags (SYNC_FIFO_ERR_EN only).
- overflow  out  1  sticky: a write was rejected (SYNC_FIFO_ERR_EN only).
- underflow  out  1  sticky: a read was rejected (SYNC_FIFO_ERR_EN only).

## Operation
- Pointers wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH. count is held in a separate register one bit wider.
- Read accept: rd && !empty. Mem[rd_ptr] is registered to data_out, rd_ptr increments, and rd_valid is 1 in the next cycle.
- Write accept: wr && (!full || rd). Data_in is written to mem[wr_ptr] and wr_ptr increments.
- Full with wr && rd: both are accepted; the read returns the oldest word and count is unchanged.
- Empty with wr && rd: only the write is accepted; no read-through. Count becomes 1 and rd_valid stays 0.
- Count update: +1 for write-only, −1 for read-only, unchanged when both or neither are accepted.
- Rejected requests have no effect on pointers, memory or count.
- data_out holds its last value when no read is accepted.
- Status flags are combinational decodes of the registered count. No other combinational path exists from inputs to outputs.
- Reset behaviour: rst clears wr_ptr, rd_ptr, count, data_out (0), rd_valid (0), overflow (0) and underflow (0). After reset, empty=1, full=0, almost_empty=1, and almost_full=0 unless AF_THRESH==0 (illegal). Memory contents are not cleared.
- Reset mid-operation: rst has priority over wr and rd in the same cycle, and all stored data is discarded.

## Timing
- Write-to-read latency: a write at edge N deasserts empty after edge N. A read presented in the following cycle is accepted at edge N+1, with data_out and rd_valid valid in cycle N+2.
- Read latency: 1 cycle from the accepting edge to data_out.
- Sustained throughput: one write and one read per cycle at any occupancy, including full.
- Flags and count change only on the rising edge after the accepting operation.

## Configuration
- SYNC_FIFO_ERR_EN defined:
  - err_clr, overflow and underflow ports exist.
  - overflow sets on wr && full && !rd.
  - underflow sets on rd && empty.
  - Both flags hold until rst, or until err_clr at an edge. If err_clr and a new error occur in the same cycle, the flag stays set.
- SYNC_FIFO_ERR_EN undefined: those three ports and their logic are absent. Rejected requests are silently dropped.

## Structure
- Package sync_fifo_pkg holds:
  - functions for pointer width and count width;
  - a parameter-legality check function, used by an elaboration-time assertion on DEPTH power of two, DEPTH ≥ 4, and threshold ranges.
- Sub-module sync_fifo_ram: a DEPTH×WIDTH array with one synchronous write port and one synchronous registered read port.
  - Its read-enable is the read-accept signal.
  - Its output register is data_out, cleared by rst.

## Test plan
- Reset then idle: empty=1, almost_empty=1, full=0, count=0, data_out=0, rd_valid=0.
- Default parameters, write 0x00..0x1F: full=1 and count=32 after the 32nd write; almost_full=1 from count 30. Reading all 32 returns 0x00..0x1F in order with rd_valid each cycle; empty=1 at the end.
- At full, wr=1 with data 0xAA plus rd=1: data_out=oldest word, count stays 32, and 0xAA is read last. wr alone at full: count stays 32 and overflow=1 (ERR_EN).
- At empty, wr=1 with 0x55 plus rd=1: rd_valid=0 next cycle and count=1. A read the next cycle returns 0x55. rd alone at empty sets underflow; err_clr clears it.
- Wrap-around: 100 cycles of simultaneous rd/wr at count=5 with incrementing data: output sequence matches input delayed by 5 words, and pointers wrap cleanly.
- Reset at count=17 with wr and rd high: next cycle count=0, empty=1, data_out=0, and a subsequent read of fresh data returns only the new data.
